pong_core: RTL

- Parametrised next-generation Pong engine. It replaces the vsync-clocked game block with a pixel-clock design that updates the game once per frame strobe.
- Adds configurable geometry and speed, both-wall bouncing, paddle clamping, per-player scoring, and a serve/point/game-over state machine.
- Emits a registered 2-bit pixel class to the VGA output stage, plus score and state outputs for the top level.

---
 rtl/pong_pkg.sv | 36 +++
 rtl/pong_render.sv | 73 +++++++
 rtl/pong_core.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared state/pixel encodings and default geometry for Pong.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam logic [1:0] c_st_serve = 2'd0;
    localparam logic [1:0] c_st_play  = 2'd1;
    localparam logic [1:0] c_st_point = 2'd2;
    localparam logic [1:0] c_st_over  = 2'd3;

    localparam logic [1:0] c_px_bg     = 2'd0;
    localparam logic [1:0] c_px_net    = 2'd1;
    localparam logic [1:0] c_px_paddle = 2'd2;
    localparam logic [1:0] c_px_ball   = 2'd3;

    localparam int c_coord_w      = 10;
    localparam int c_h_active     = 640;
    localparam int c_v_active     = 480;
    localparam int c_ball_size    = 4;
    localparam int c_ball_speed   = 4;
    localparam int c_paddle_w     = 4;
    localparam int c_paddle_h     = 50;
    localparam int c_p1_x         = 10;
    localparam int c_p2_x         = 626;
    localparam int c_net_x        = 320;
    localparam int c_net_w        = 3;
    localparam int c_score_w      = 4;
    localparam int c_win_score    = 11;
    localparam int c_serve_frames = 60;
    localparam int c_point_frames = 30;

endpackage
`default_nettype wire

// File: rtl/pong_render.sv
`default_nettype none
// ============================================================================
// Module      : pong_render
// Description : Object hit tests and registered 2-bit pixel class output.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_render
    import pong_pkg::*;
#(
    parameter int COORD_W   = c_coord_w,
    parameter int BALL_SIZE = c_ball_size,
    parameter int PADDLE_W  = c_paddle_w,
    parameter int PADDLE_H  = c_paddle_h,
    parameter int P1_X      = c_p1_x,
    parameter int P2_X      = c_p2_x,
    parameter int NET_X     = c_net_x,
    parameter int NET_W     = c_net_w
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] i_ball_h,
    input  logic [COORD_W-1:0] i_ball_v,
    input  logic [COORD_W-1:0] i_paddle1,
    input  logic [COORD_W-1:0] i_paddle2,
    input  logic               i_ball_visible,
    input  logic [COORD_W-1:0] i_hpos,
    input  logic [COORD_W-1:0] i_vpos,
    input  logic               i_de,
    output logic [1:0]         o_pixel
);

    localparam logic [COORD_W-1:0] c_ball_sz = COORD_W'(BALL_SIZE);
    localparam logic [COORD_W-1:0] c_pad_w   = COORD_W'(PADDLE_W);
    localparam logic [COORD_W-1:0] c_pad_h   = COORD_W'(PADDLE_H);
    localparam logic [COORD_W-1:0] c_p1x     = COORD_W'(P1_X);
    localparam logic [COORD_W-1:0] c_p2x     = COORD_W'(P2_X);
    localparam logic [COORD_W-1:0] c_netx    = COORD_W'(NET_X);
    localparam logic [COORD_W-1:0] c_netw    = COORD_W'(NET_W);

    logic       w_in_ball;
    logic       w_in_pad1;
    logic       w_in_pad2;
    logic       w_in_net;
    logic [1:0] r_pixel;

    // Unsigned wrap-around makes "pos - origin < size" a single-sided range test
    assign w_in_ball = i_ball_visible
                     && ((i_hpos - i_ball_h) < c_ball_sz)
                     && ((i_vpos - i_ball_v) < c_ball_sz);
    assign w_in_pad1 = ((i_hpos - c_p1x) < c_pad_w) && ((i_vpos - i_paddle1) < c_pad_h);
    assign w_in_pad2 = ((i_hpos - c_p2x) < c_pad_w) && ((i_vpos - i_paddle2) < c_pad_h);
    assign w_in_net  = ((i_hpos - c_netx) < c_netw) && i_vpos[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pixel <= c_px_bg;
        end else if (!i_de) begin
            r_pixel <= c_px_bg;
        end else if (w_in_ball) begin
            r_pixel <= c_px_ball;
        end else if (w_in_pad1 || w_in_pad2) begin
            r_pixel <= c_px_paddle;
        end else if (w_in_net) begin
            r_pixel <= c_px_net;
        end else begin
            r_pixel <= c_px_bg;
        end
    end

    assign o_pixel = r_pixel;

endmodule
`default_nettype wire

// File: rtl/pong_core.sv
`default_nettype none
// ============================================================================
// Module      : pong_core
// Description : Pong game FSM, ball physics, paddles and scoring per frame tick.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_core
    import pong_pkg::*;
#(
    parameter int COORD_W      = c_coord_w,
    parameter int H_ACTIVE     = c_h_active,
    parameter int V_ACTIVE     = c_v_active,
    parameter int BALL_SIZE    = c_ball_size,
    parameter int BALL_SPEED   = c_ball_speed,
    parameter int PADDLE_W     = c_paddle_w,
    parameter int PADDLE_H     = c_paddle_h,
    parameter int P1_X         = c_p1_x,
    parameter int P2_X         = c_p2_x,
    parameter int NET_X        = c_net_x,
    parameter int NET_W        = c_net_w,
    parameter int SCORE_W      = c_score_w,
    parameter int WIN_SCORE    = c_win_score,
    parameter int SERVE_FRAMES = c_serve_frames,
    parameter int POINT_FRAMES = c_point_frames
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [COORD_W-1:0] paddle1_next,
    input  logic [COORD_W-1:0] paddle2_next,
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    input  logic               de,
    output logic [1:0]         pixel,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         game_state,
    output logic               point_pulse
);

    localparam int c_xw        = COORD_W + 1;
    localparam int c_timer_max = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int c_timer_w   = $clog2(c_timer_max + 1);

    localparam logic [c_timer_w-1:0] c_serve_ld = c_timer_w'(SERVE_FRAMES - 1);
    localparam logic [c_timer_w-1:0] c_point_ld = c_timer_w'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0]   c_win      = SCORE_W'(WIN_SCORE);

    localparam logic [COORD_W-1:0] c_ctr_h   = COORD_W'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] c_ctr_v   = COORD_W'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] c_pad_max = COORD_W'(V_ACTIVE - PADDLE_H);
    localparam logic [COORD_W-1:0] c_spd     = COORD_W'(BALL_SPEED);
    localparam logic [COORD_W-1:0] c_v_lim   = COORD_W'(V_ACTIVE - BALL_SIZE);
    localparam logic [COORD_W-1:0] c_p1_face = COORD_W'(P1_X + PADDLE_W);
    localparam logic [COORD_W-1:0] c_p2_stop = COORD_W'(P2_X - BALL_SIZE);

    localparam logic [c_xw-1:0] c_spd_w   = c_xw'(BALL_SPEED);
    localparam logic [c_xw-1:0] c_ball_w  = c_xw'(BALL_SIZE);
    localparam logic [c_xw-1:0] c_pad_h_w = c_xw'(PADDLE_H);
    localparam logic [c_xw-1:0] c_v_lim_w = c_xw'(V_ACTIVE - BALL_SIZE);
    localparam logic [c_xw-1:0] c_h_lim_w = c_xw'(H_ACTIVE - BALL_SIZE);
    localparam logic [c_xw-1:0] c_p1f_w   = c_xw'(P1_X + PADDLE_W);
    localparam logic [c_xw-1:0] c_p2x_w   = c_xw'(P2_X);

    logic [1:0]           r_state;
    logic [c_timer_w-1:0] r_timer;
    logic [COORD_W-1:0]   r_ball_h;
    logic [COORD_W-1:0]   r_ball_v;
    logic                 r_h_dir;
    logic                 r_v_dir;
    logic [SCORE_W-1:0]   r_score1;
    logic [SCORE_W-1:0]   r_score2;
    logic [COORD_W-1:0]   r_paddle1;
    logic [COORD_W-1:0]   r_paddle2;
    logic                 r_point_pulse;

    logic [c_xw-1:0]    w_bh, w_bv, w_p1, w_p2;
    logic [COORD_W-1:0] w_pad1_clamp, w_pad2_clamp;
    logic               w_ov1, w_ov2, w_hit1, w_hit2, w_miss_l, w_miss_r;
    logic [COORD_W-1:0] w_bh_nx, w_bv_nx;
    logic               w_hd_nx, w_vd_nx;

    assign w_bh = c_xw'(r_ball_h);
    assign w_bv = c_xw'(r_ball_v);
    assign w_p1 = c_xw'(r_paddle1);
    assign w_p2 = c_xw'(r_paddle2);

    assign w_pad1_clamp = (paddle1_next > c_pad_max) ? c_pad_max : paddle1_next;
    assign w_pad2_clamp = (paddle2_next > c_pad_max) ? c_pad_max : paddle2_next;

    // Overlap uses the paddle positions from before this tick's update
    assign w_ov1 = (w_bv + c_ball_w > w_p1) && (w_bv < w_p1 + c_pad_h_w);
    assign w_ov2 = (w_bv + c_ball_w > w_p2) && (w_bv < w_p2 + c_pad_h_w);

    assign w_hit1   = !r_h_dir && w_ov1 && (w_bh >= c_p1f_w) && (w_bh < c_p1f_w + c_spd_w);
    assign w_hit2   = r_h_dir && w_ov2 && (w_bh + c_ball_w + c_spd_w > c_p2x_w)
                    && (w_bh + c_ball_w <= c_p2x_w);
    assign w_miss_l = !r_h_dir && (w_bh < c_spd_w) && !w_hit1;
    assign w_miss_r = r_h_dir && (w_bh + c_spd_w > c_h_lim_w) && !w_hit2;

    always_comb begin
        w_bv_nx = r_ball_v;
        w_vd_nx = r_v_dir;
        if (r_v_dir) begin
            if (w_bv + c_spd_w >= c_v_lim_w) begin
                w_bv_nx = c_v_lim;
                w_vd_nx = 1'b0;
            end else begin
                w_bv_nx = r_ball_v + c_spd;
            end
        end else if (w_bv < c_spd_w) begin
            w_bv_nx = '0;
            w_vd_nx = 1'b1;
        end else begin
            w_bv_nx = r_ball_v - c_spd;
        end

        w_hd_nx = r_h_dir;
        w_bh_nx = r_h_dir ? (r_ball_h + c_spd) : (r_ball_h - c_spd);
        if (w_hit1) begin
            w_bh_nx = c_p1_face;
            w_hd_nx = 1'b1;
        end else if (w_hit2) begin
            w_bh_nx = c_p2_stop;
            w_hd_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_serve;
            r_timer       <= c_serve_ld;
            r_ball_h      <= c_ctr_h;
            r_ball_v      <= c_ctr_v;
            r_h_dir       <= 1'b0;
            r_v_dir       <= 1'b1;
            r_score1      <= '0;
            r_score2      <= '0;
            r_paddle1     <= '0;
            r_paddle2     <= '0;
            r_point_pulse <= 1'b0;
        end else begin
            r_point_pulse <= 1'b0;
            if (frame_tick) begin
                r_paddle1 <= w_pad1_clamp;
                r_paddle2 <= w_pad2_clamp;
                case (r_state)
                    c_st_serve: begin
                        r_ball_h <= c_ctr_h;
                        r_ball_v <= c_ctr_v;
                        if (r_timer == '0) r_state <= c_st_play;
                        else               r_timer <= r_timer - 1'b1;
                    end
                    c_st_play: begin
                        // h_dir is left untouched on a miss so it already points at the loser
                        if (w_miss_l || w_miss_r) begin
                            if (w_miss_l && r_score2 != c_win) r_score2 <= r_score2 + 1'b1;
                            if (w_miss_r && r_score1 != c_win) r_score1 <= r_score1 + 1'b1;
                            r_point_pulse <= 1'b1;
                            r_timer       <= c_point_ld;
                            r_state       <= c_st_point;
                        end else begin
                            r_ball_h <= w_bh_nx;
                            r_ball_v <= w_bv_nx;
                            r_h_dir  <= w_hd_nx;
                            r_v_dir  <= w_vd_nx;
                        end
                    end
                    c_st_point: begin
                        if (r_timer != '0) begin
                            r_timer <= r_timer - 1'b1;
                        end else if (r_score1 == c_win || r_score2 == c_win) begin
                            r_state <= c_st_over;
                        end else begin
                            r_ball_h <= c_ctr_h;
                            r_ball_v <= c_ctr_v;
                            r_timer  <= c_serve_ld;
                            r_state  <= c_st_serve;
                        end
                    end
                    default: begin
                        if (start) begin
                            r_score1 <= '0;
                            r_score2 <= '0;
                            r_h_dir  <= 1'b0;
                            r_ball_h <= c_ctr_h;
                            r_ball_v <= c_ctr_v;
                            r_timer  <= c_serve_ld;
                            r_state  <= c_st_serve;
                        end
                    end
                endcase
            end
        end
    end

    pong_render #(
        .COORD_W   (COORD_W),
        .BALL_SIZE (BALL_SIZE),
        .PADDLE_W  (PADDLE_W),
        .PADDLE_H  (PADDLE_H),
        .P1_X      (P1_X),
        .P2_X      (P2_X),
        .NET_X     (NET_X),
        .NET_W     (NET_W)
    ) u_render (
        .clk            (clk),
        .reset          (reset),
        .i_ball_h       (r_ball_h),
        .i_ball_v       (r_ball_v),
        .i_paddle1      (r_paddle1),
        .i_paddle2      (r_paddle2),
        .i_ball_visible (r_state != c_st_over),
        .i_hpos         (hpos),
        .i_vpos         (vpos),
        .i_de           (de),
        .o_pixel        (pixel)
    );

    assign score1      = r_score1;
    assign score2      = r_score2;
    assign game_state  = r_state;
    assign point_pulse = r_point_pulse;

endmodule
`default_nettype wire
